// File: rtl/serial_to_parallel_rx_if.sv
// serial_to_parallel_rx_if: serial input and parallel byte output bundle of the deserializer
interface serial_to_parallel_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;
  modport master(input data_in, output data_out, valid_out, byte_stb, active);
  modport slave(output data_in, input data_out, valid_out, byte_stb, active);
endinterface

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: MSB-first deserializer with comma-based byte alignment and lock detection
module serial_to_parallel_rx #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input logic clk_8f,
  input logic reset,
  serial_to_parallel_rx_if.master bus
);
  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [3:0] LC     = 4'(LOCK_COUNT);
  logic [7:0] sr, w, data_q;
  logic [2:0] bit_cnt;
  logic [3:0] comma_cnt;
  logic [1:0] state;
  logic       valid_q, stb_q, is_comma, boundary;
  assign w        = {sr[6:0], bus.data_in};
  assign is_comma = w == COMMA;
  assign boundary = bit_cnt == 3'd7;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.byte_stb  = stb_q;
  assign bus.active    = state == LOCKED;
  always_ff @(posedge clk_8f or posedge reset)
    if (reset) begin
      state     <= HUNT;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      sr    <= w;
      stb_q <= 1'b0;
      case (state)
        HUNT:
          if (is_comma) begin
            bit_cnt   <= '0;
            comma_cnt <= 4'd1;
            state     <= (LC == 4'd1) ? LOCKED : ALIGN;
          end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary && !is_comma) begin
            state     <= HUNT;
            comma_cnt <= '0;
          end else if (boundary) begin
            comma_cnt <= comma_cnt + 4'd1;
            state     <= (comma_cnt + 4'd1 == LC) ? LOCKED : ALIGN;
          end
        end
        default: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            data_q  <= w;
            valid_q <= !is_comma;
            stb_q   <= 1'b1;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: directed checks of alignment, lock, data delivery and reset behaviour
module tb_serial_to_parallel_rx;
  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  logic din    = 1'b0;
  int   pass   = 0;
  int   total  = 0;
  int   stb_cnt = 0;
  serial_to_parallel_rx_if b1 ();
  serial_to_parallel_rx_if b2 ();
  assign b1.data_in = din;
  assign b2.data_in = din;
  serial_to_parallel_rx dut (.clk_8f(clk_8f), .reset(reset), .bus(b1));
  serial_to_parallel_rx #(.LOCK_COUNT(1)) dut1 (.clk_8f(clk_8f), .reset(reset), .bus(b2));
  always #5 clk_8f = ~clk_8f;

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk_8f);
    #1;
    if (b1.byte_stb) stb_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_8f);
    #1;
    reset = 1'b0;
    stb_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (b1.data_out !== 8'h00) $display("FAIL rst_data got %h exp 00", b1.data_out); else pass++;
    total++; if ({b1.valid_out, b1.byte_stb, b1.active} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {b1.valid_out, b1.byte_stb, b1.active}); else pass++;
  endtask

  task automatic test_clean_lock();
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (3) send_byte(8'hBC);
    total++; if (b1.active !== 1'b0) $display("FAIL lock_early got %b exp 0", b1.active); else pass++;
    send_byte(8'hBC);
    total++; if (b1.active !== 1'b1) $display("FAIL lock_active got %b exp 1", b1.active); else pass++;
    total++; if (stb_cnt !== 0 || b1.data_out !== 8'h00) $display("FAIL lock_no_stb got stb=%0d data=%h exp stb=0 data=00", stb_cnt, b1.data_out); else pass++;
    send_byte(8'h3A);
    total++; if ({b1.byte_stb, b1.valid_out, b1.data_out} !== {2'b11, 8'h3A}) $display("FAIL lock_3a got stb=%b v=%b d=%h exp 1 1 3a", b1.byte_stb, b1.valid_out, b1.data_out); else pass++;
    send_bit(1'b1);
    total++; if (b1.byte_stb !== 1'b0 || b1.data_out !== 8'h3A) $display("FAIL lock_hold got stb=%b d=%h exp 0 3a", b1.byte_stb, b1.data_out); else pass++;
    for (int i = 6; i >= 0; i--) send_bit(1'(8'hC5 >> i));
    total++; if ({b1.byte_stb, b1.valid_out, b1.data_out} !== {2'b11, 8'hC5}) $display("FAIL lock_c5 got stb=%b v=%b d=%h exp 1 1 c5", b1.byte_stb, b1.valid_out, b1.data_out); else pass++;
  endtask

  task automatic test_idle_locked();
    logic [7:0] seq [3] = '{8'hBC, 8'h77, 8'hBC};
    logic       vld [3] = '{1'b0, 1'b1, 1'b0};
    stb_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      send_byte(seq[k]);
      total++; if ({b1.byte_stb, b1.valid_out, b1.data_out} !== {1'b1, vld[k], seq[k]}) $display("FAIL idle_%0d got stb=%b v=%b d=%h exp 1 %b %h", k, b1.byte_stb, b1.valid_out, b1.data_out, vld[k], seq[k]); else pass++;
    end
    total++; if (stb_cnt !== 3) $display("FAIL idle_stbs got %0d exp 3", stb_cnt); else pass++;
  endtask

  task automatic test_reset_midstream();
    send_byte(8'h5A);
    total++; if (b1.valid_out !== 1'b1) $display("FAIL mid_pre got %b exp 1", b1.valid_out); else pass++;
    #1 reset = 1'b1;
    #1;
    total++; if ({b1.data_out, b1.valid_out, b1.active} !== 10'h000) $display("FAIL mid_async got d=%h v=%b a=%b exp 00 0 0", b1.data_out, b1.valid_out, b1.active); else pass++;
    @(posedge clk_8f);
    #1 reset = 1'b0;
    stb_cnt = 0;
    repeat (3) send_byte(8'hBC);
    total++; if (b1.active !== 1'b0) $display("FAIL mid_relock_early got %b exp 0", b1.active); else pass++;
    send_byte(8'hBC);
    total++; if (b1.active !== 1'b1 || stb_cnt !== 0) $display("FAIL mid_relock got a=%b stb=%0d exp 1 0", b1.active, stb_cnt); else pass++;
  endtask

  task automatic test_broken_run();
    do_reset();
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h55);
    repeat (3) send_byte(8'hBC);
    total++; if (b1.active !== 1'b0) $display("FAIL broken_early got %b exp 0", b1.active); else pass++;
    send_byte(8'hBC);
    total++; if (b1.active !== 1'b1) $display("FAIL broken_lock got %b exp 1", b1.active); else pass++;
    send_byte(8'h12);
    total++; if ({b1.byte_stb, b1.valid_out, b1.data_out} !== {2'b11, 8'h12} || stb_cnt !== 1) $display("FAIL broken_12 got stb=%b v=%b d=%h n=%0d exp 1 1 12 1", b1.byte_stb, b1.valid_out, b1.data_out, stb_cnt); else pass++;
  endtask

  task automatic test_misaligned();
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1)));
    repeat (4) send_byte(8'hBC);
    total++; if (b1.active !== 1'b1 || stb_cnt !== 0) $display("FAIL mis_lock got a=%b stb=%0d exp 1 0", b1.active, stb_cnt); else pass++;
    send_byte(8'hA5);
    total++; if ({b1.byte_stb, b1.valid_out, b1.data_out} !== {2'b11, 8'hA5}) $display("FAIL mis_a5 got stb=%b v=%b d=%h exp 1 1 a5", b1.byte_stb, b1.valid_out, b1.data_out); else pass++;
  endtask

  task automatic test_lock_one();
    do_reset();
    total++; if (b2.active !== 1'b0) $display("FAIL lc1_rst got %b exp 0", b2.active); else pass++;
    send_byte(8'hBC);
    total++; if (b2.active !== 1'b1 || b2.byte_stb !== 1'b0) $display("FAIL lc1_lock got a=%b stb=%b exp 1 0", b2.active, b2.byte_stb); else pass++;
    send_byte(8'h9F);
    total++; if ({b2.byte_stb, b2.valid_out, b2.data_out} !== {2'b11, 8'h9F}) $display("FAIL lc1_9f got stb=%b v=%b d=%h exp 1 1 9f", b2.byte_stb, b2.valid_out, b2.data_out); else pass++;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_idle_locked();
    test_reset_midstream();
    test_broken_run();
    test_misaligned();
    test_lock_one();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Receive-side counterpart of the PHY serializer; sits directly downstream of the serial link, in the `clk_8f` domain.
- Deserializes an MSB-first bit stream and hunts for byte alignment using the idle comma `8'hBC`.
- Declares lock after a programmable run of aligned commas.
- Once locked, delivers each byte in parallel with a valid flag; idle commas are flagged invalid.

Parameters:
- `COMMA`, `8'hBC`: idle/alignment symbol sent by the transmitter when no valid data is present.
- `LOCK_COUNT`, 4: number of consecutive aligned commas, including the first detected, required to enter LOCKED; legal range 1..15.

Ports:
- `clk_8f` input 1: bit clock, one serial bit per rising edge; the only clock.
- `reset` input 1: asynchronous, active-high reset.
- `data_in` input 1: serial bit stream, MSB of each byte first.
- `data_out` output 8: last deserialized byte, held stable between byte boundaries.
- `valid_out` output 1: 1 when `data_out` holds a non-comma byte captured while LOCKED.
- `byte_stb` output 1: one-cycle pulse on each `clk_8f` cycle in which `data_out`/`valid_out` update.
- `active` output 1: 1 while in LOCKED state.

Behaviour:
- Internal registers:
  - `sr[7:0]`: shift register, shifts every cycle; `sr <= {sr[6:0], data_in}`.
  - `w`: combinational window, `w = {sr[6:0], data_in}`; it is the byte whose last bit is being sampled this edge.
  - `bit_cnt[2:0]`, `comma_cnt[3:0]`, `state` in {HUNT, ALIGN, LOCKED}.
- Reset (async, while `reset` high):
  - `state` = HUNT; `sr`, `bit_cnt`, `comma_cnt` = 0.
  - `data_out` = `8'h00`; `valid_out` = 0; `byte_stb` = 0; `active` = 0.
  - Reset asserted mid-byte or while LOCKED aborts immediately; on release, the block re-hunts from scratch.
- HUNT: `w` is compared against `COMMA` every cycle, at any bit phase.
  - On `w == COMMA`: `bit_cnt <= 0`, `comma_cnt <= 1`.
  - If `LOCK_COUNT == 1`, go to LOCKED; otherwise go to ALIGN.
  - No outputs change in HUNT.
- Byte boundary, ALIGN and LOCKED:
  - `bit_cnt` increments mod 8 each cycle.
  - Boundary = cycle where `bit_cnt == 7`; `w` is then the complete byte.
- ALIGN, at boundary:
  - `w == COMMA`: `comma_cnt` increments; if new value equals `LOCK_COUNT`, go to LOCKED and set `active <= 1` on that edge.
  - `w != COMMA`: go to HUNT, `comma_cnt <= 0`.
  - Non-boundary cycles: hold.
- LOCKED, at boundary:
  - `data_out <= w`.
  - `valid_out <= (w != COMMA)`.
  - `byte_stb <= 1`.
  - `byte_stb` is 0 on all other cycles; `data_out`/`valid_out` hold for 8 cycles.
- Lock timing: the comma that completes the lock sequence is not presented on `data_out`. The first `byte_stb` occurs at the next boundary (8 cycles later).
- Latency: registered outputs update on the edge where the last bit of a byte is sampled. They are visible the cycle after that bit is on `data_in`.
- Lock retention: LOCKED is left only by reset; data bytes equal to `COMMA` are treated as idle.
- `comma_cnt` saturates at `LOCK_COUNT`; no wrap.
- Spurious comma-like pattern straddling two bytes in HUNT: alignment is taken; ALIGN rejects it at the next boundary unless followed by a true comma.

Test Plan:
- Reset mid-stream: assert `reset` while LOCKED with `valid_out = 1`. Required: `data_out = 00`, `valid_out = 0`, `active = 0` immediately, without waiting for a clock; re-lock needs `LOCK_COUNT` fresh commas.
- Clean lock: 3 junk bits `101`, then 4x `BC`, then `3A`, `C5`. Required:
  - `active` rises on the edge sampling the last bit of the 4th `BC`.
  - `byte_stb` pulses 8 and 16 cycles later with `data_out = 3A`, `valid_out = 1`, then `data_out = C5`, `valid_out = 1`.
- Idle while locked: after lock, send `BC`, `77`, `BC`. Required: three strobes, `valid_out` sequence 0, 1, 0; `data_out` sequence BC, 77, BC.
- Broken comma run: `BC`, `BC`, `55`, then 4x `BC`, `12`. Required:
  - Return to HUNT after `55`.
  - `active` asserted only after the later 4 commas.
  - First valid byte is `12`.
- Misaligned start: prepend 5 random bits, then the stream `BC BC BC BC A5`. Required: lock at the correct phase and `data_out = A5` with `valid_out = 1`; no strobes before `active`.
- `LOCK_COUNT = 1` override: single `BC`, then `9F`. Required: `active` after the first comma; strobe with `data_out = 9F`, `valid_out = 1` 8 cycles later.
